// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - single-port memory arbiter for NRISC fetch/data requesters
// Optional ARB_RR_EN: round-robin tie-break instead of fixed data-over-fetch priority.
module arbitro_memoria #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_data,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;   // 1 = data requester owns the access
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_data_q, if_data_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          we_d;
    logic          grant_data;
    logic          mem_en_q, mem_we_q, if_ack_q, d_ack_q, busy_q;

`ifdef ARB_RR_EN
    logic last_q, last_d;              // 1 = data was granted last
    assign grant_data = d_req & (~if_req | ~last_q);
`else
    assign grant_data = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;
        we_d      = 1'b0;
`ifdef ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!halt && (if_req || d_req)) begin
                    owner_d = grant_data;
                    addr_d  = grant_data ? d_addr : if_addr;
                    wdata_d = grant_data ? d_wdata : wdata_q;
                    we_d    = grant_data & d_we;
                    state_d = S_ISSUE;
`ifdef ARB_RR_EN
                    last_d  = grant_data;
`endif
                end
            end
            S_ISSUE: begin
                // mem_we_q is only ever high during ISSUE, so it doubles as the latched we
                if (mem_we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (owner_q) d_rdata_d = mem_rdata;
                    else         if_data_d = mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
            mem_en_q  <= (state_d == S_ISSUE);
            mem_we_q  <= we_d;
            if_ack_q  <= (state_d == S_RESP) & ~owner_q;
            d_ack_q   <= (state_d == S_RESP) & owner_q;
            busy_q    <= (state_d != S_IDLE);
`ifdef ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_data   = if_data_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb/tb_arbitro_memoria.sv - scoreboard bench for arbitro_memoria with latency memory model
module tb_arbitro_memoria;
    localparam int LAT = 3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       halt = 1'b0, if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0] if_addr = 8'h00, d_addr = 8'h00, d_wdata = 8'h00;
    logic       if_ack, d_ack, mem_en, mem_we, stall, busy;
    logic [7:0] if_data, d_rdata, mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        bit         st;
        logic [7:0] addr;
        logic [7:0] val;
    } exp_t;

    exp_t       if_q[$];
    exp_t       d_q[$];
    logic [7:0] ref_mem[256];
    logic [7:0] mem[256];
    logic       pv[1:4];
    logic [7:0] pa[1:4];
    logic [7:0] garb;
    int         checks = 0;
    int         failures = 0;

    arbitro_memoria #(.AW(8), .DW(8), .MEM_LAT(LAT)) dut (
        .Clock(Clock), .Reset(Reset), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .busy(busy)
    );

    always #5 Clock = ~Clock;

    // Memory: read data is valid only in the cycle LAT cycles after mem_en, garbage otherwise
    always @(posedge Clock) begin
        garb  <= 8'($urandom);
        pv[1] <= mem_en & ~mem_we;
        pa[1] <= mem_addr;
        for (int k = 2; k <= 4; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = pv[LAT] ? mem[pa[LAT]] : garb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_msg(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=none expected=event", nm);
    endtask

    initial begin
        int         en_cnt;
        logic       l_we;
        logic [7:0] l_addr, l_wd;
        exp_t       e;
        en_cnt = 0;
        l_we = 1'b0; l_addr = 8'h00; l_wd = 8'h00;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                en_cnt = 0;
            end else begin
                if (mem_en) begin
                    en_cnt++;
                    l_we = mem_we; l_addr = mem_addr; l_wd = mem_wdata;
                end
                if (!if_ack && !d_ack) chk("stall", stall, if_req | d_req);
                if (if_ack) begin
                    chk("acks_exclusive", d_ack, 0);
                    if (if_q.size() == 0) fail_msg("if_ack_unexpected");
                    else begin
                        e = if_q.pop_front();
                        chk("if_mem_en_count", en_cnt, 1);
                        chk("if_mem_we", l_we, 0);
                        chk("if_mem_addr", l_addr, e.addr);
                        chk("if_data", if_data, e.val);
                    end
                    en_cnt = 0;
                end
                if (d_ack) begin
                    if (d_q.size() == 0) fail_msg("d_ack_unexpected");
                    else begin
                        e = d_q.pop_front();
                        chk("d_mem_en_count", en_cnt, 1);
                        chk("d_mem_we", l_we, e.st);
                        chk("d_mem_addr", l_addr, e.addr);
                        if (e.st) chk("d_mem_wdata", l_wd, e.val);
                        else      chk("d_rdata", d_rdata, e.val);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    task automatic wait_ack(input bit side, input int halt_at, input bit timed,
                            output int en_c, output int ack_c);
        int cyc = 0;
        en_c = -1;
        ack_c = -1;
        while (ack_c < 0 && cyc < 300) begin
            @(negedge Clock);
            if (mem_en) en_c = cyc;
            if (timed && cyc == 1) chk("busy_in_issue", busy, 1);
            if (cyc == halt_at) halt = 1'b1;
            if (side ? d_ack : if_ack) ack_c = cyc;
            cyc++;
        end
        if (ack_c < 0) fail_msg(side ? "d_ack_timeout" : "if_ack_timeout");
        @(posedge Clock); #1;
        if (side) d_req = 1'b0; else if_req = 1'b0;
        if (halt_at >= 0) halt = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input int halt_at, input bit timed,
                         output int en_c, output int ack_c);
        exp_t e;
        e.st = 1'b0; e.addr = a; e.val = ref_mem[a];
        if_q.push_back(e);
        @(posedge Clock); #1;
        if_req = 1'b1; if_addr = a;
        wait_ack(1'b0, halt_at, timed, en_c, ack_c);
    endtask

    task automatic dacc(input bit we, input logic [7:0] a, input logic [7:0] w, input bit timed,
                        output int en_c, output int ack_c);
        exp_t e;
        e.st = we; e.addr = a;
        if (we) begin
            e.val = w;
            ref_mem[a] = w;
        end else begin
            e.val = ref_mem[a];
        end
        d_q.push_back(e);
        @(posedge Clock); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
        wait_ack(1'b1, -1, timed, en_c, ack_c);
    endtask

    task automatic prio_test(input bit fetch_first);
        int fe, fa, de, da;
        fork
            fetch(8'h11, -1, 1'b0, fe, fa);
            dacc(1'b1, 8'h21, 8'($urandom), 1'b0, de, da);
        join
        if (fetch_first) begin
            chk("prio_fetch_en", fe, 1);
            chk("prio_fetch_ack", fa, 2 + LAT);
            chk("prio_data_en", de, 4 + LAT);
            chk("prio_data_ack", da, 5 + LAT);
        end else begin
            chk("prio_data_en", de, 1);
            chk("prio_data_ack", da, 2);
            chk("prio_fetch_en", fe, 4);
            chk("prio_fetch_ack", fa, 5 + LAT);
        end
    endtask

    initial begin
        int   en_c, ack_c;
        exp_t e;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'hA5;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_stall", stall, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        fetch(8'h10, -1, 1'b1, en_c, ack_c);
        chk("fetch_en_cycle", en_c, 1);
        chk("fetch_ack_cycle", ack_c, 2 + LAT);
        dacc(1'b1, 8'h20, 8'h3C, 1'b1, en_c, ack_c);
        chk("store_en_cycle", en_c, 1);
        chk("store_ack_cycle", ack_c, 2);
        dacc(1'b0, 8'h20, 8'h00, 1'b1, en_c, ack_c);
        chk("load_en_cycle", en_c, 1);
        chk("load_ack_cycle", ack_c, 2 + LAT);

`ifdef ARB_RR_EN
        prio_test(1'b1);
        prio_test(1'b1);
`else
        prio_test(1'b0);
        prio_test(1'b0);
`endif
        fetch(8'h12, -1, 1'b1, en_c, ack_c);
        prio_test(1'b0);

        e.st = 1'b0; e.addr = 8'h33; e.val = ref_mem[8'h33];
        if_q.push_back(e);
        @(posedge Clock); #1;
        halt = 1'b1; if_req = 1'b1; if_addr = 8'h33;
        repeat (4) begin
            @(negedge Clock);
            chk("halt_no_mem_en", mem_en, 0);
            chk("halt_stall", stall, 1);
            chk("halt_not_busy", busy, 0);
        end
        @(posedge Clock); #1;
        halt = 1'b0;
        wait_ack(1'b0, -1, 1'b1, en_c, ack_c);
        chk("unhalt_ack_cycle", ack_c, 2 + LAT);

        fetch(8'h44, 2, 1'b1, en_c, ack_c);
        chk("halt_wait_ack_cycle", ack_c, 2 + LAT);

        @(posedge Clock); #1;
        if_req = 1'b1; if_addr = 8'h55;
        repeat (3) @(negedge Clock);
        Reset = 1'b1; if_req = 1'b0;
        @(negedge Clock);
        chk("mid_rst_if_ack", if_ack, 0);
        chk("mid_rst_d_ack", d_ack, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_if_data", if_data, 0);
        chk("mid_rst_d_rdata", d_rdata, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        repeat (8) begin
            @(negedge Clock);
            chk("post_rst_no_ack", if_ack | d_ack, 0);
            chk("post_rst_idle", busy, 0);
        end
        fetch(8'h55, -1, 1'b1, en_c, ack_c);
        chk("post_rst_fetch_ack", ack_c, 2 + LAT);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int e1, a1;
                    repeat ($urandom_range(0, 3)) @(posedge Clock);
                    fetch(8'($urandom_range(0, 127)), -1, 1'b0, e1, a1);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int e2, a2;
                    repeat ($urandom_range(0, 3)) @(posedge Clock);
                    dacc(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)),
                         8'($urandom), 1'b0, e2, a2);
                end
            end
            begin
                for (int i = 0; i < 600; i++) begin
                    @(posedge Clock); #1;
                    halt = ($urandom_range(0, 7) == 0);
                end
                halt = 1'b0;
            end
        join

        repeat (10) @(negedge Clock);
        chk("if_queue_drained", if_q.size(), 0);
        chk("d_queue_drained", d_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Single-port memory arbiter for the NRISC core. Shares one 8-bit memory between the instruction-fetch requester (PC side) and the data requester (load/store side) through a req/ack handshake. Sequences each access through a fixed-latency issue/wait/respond state machine and raises `stall` so the core holds `EscPC` and register writes until its access completes.

## Interface
Parameters:
- `AW`, 8, address width
- `DW`, 8, data width
- `MEM_LAT`, 1, memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..4, other values illegal

Ports:
- `Clock`  in  1  single clock, all state on rising edge
- `Reset`  in  1  synchronous, active-high
- `halt`  in  1  blocks new grants; an in-flight access completes
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  AW  fetch address
- `if_ack`  out  1  one-cycle pulse: fetch done, `if_data` valid
- `if_data`  out  DW  fetched instruction, held until next fetch capture
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_ack`  out  1  one-cycle pulse: data access done
- `d_rdata`  out  DW  load result, held until next load capture
- `mem_en`  out  1  memory access strobe, exactly one cycle per access
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data
- `stall`  out  1  combinational: `(if_req & ~if_ack) | (d_req & ~d_ack)`
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `halt`=0 and any request is pending, grant one requester. Latch the owner, address, `we` and `wdata`, then go to ISSUE. Otherwise stay in IDLE.
- Fetch is always a read (`mem_we`=0).
- ISSUE: `mem_en`=1 and `mem_addr`/`mem_we`/`mem_wdata` come from the latch.
  - Write: go to RESP.
  - Read: load the latency counter with `MEM_LAT`-1 and go to WAIT.
- WAIT: count down.
  - At count 0, capture `mem_rdata` into `if_data` or `d_rdata`, according to the owner, and go to RESP.
  - Counter is 2 bits; `MEM_LAT`=1 means a single WAIT cycle.
- RESP: pulse the owner's ack, then go to IDLE. No grant is made in RESP, because the requester's `req` is still high in the ack cycle.
- Priority without the macro is fixed: `d_req` beats `if_req` when both are high in an IDLE cycle.
- A requester may change `addr`/`wdata` only after ack. After ack it may re-raise `req` at the earliest in the cycle following ack.
- Simultaneous events:
  - A request that arrives while the FSM is not in IDLE waits; it is never dropped.
  - `halt` rising in ISSUE/WAIT/RESP does not abort the access. Its ack still issues.
- Reset values:
  - FSM=IDLE, counter=0, owner=fetch, RR pointer=fetch.
  - `if_ack`=`d_ack`=`mem_en`=`mem_we`=`busy`=0.
  - `mem_addr`=`mem_wdata`=`if_data`=`d_rdata`=0.
- Reset mid-access abandons the access: no ack issues, and late `mem_rdata` is ignored.

## Timing
- Grant in IDLE cycle G; `mem_en` high in G+1.
- Read: `mem_rdata` sampled at end of cycle G+1+`MEM_LAT`; ack in G+2+`MEM_LAT`; IDLE in G+3+`MEM_LAT`.
  - Total 4 cycles at `MEM_LAT`=1.
- Write: memory written at end of G+1; ack in G+2; IDLE in G+3.
- Back-to-back reads from one requester sustain 1 access per `MEM_LAT`+3 cycles. Back-to-back writes sustain 1 per 3 cycles.
- `if_ack`, `d_ack`, `mem_*` and `busy` are registered. `stall` is combinational.

## Configuration
- `ARB_RR_EN` defined: round-robin tie-break. When both requests are pending in IDLE, the requester not granted last wins. The pointer updates on every grant, including uncontested grants.
- `ARB_RR_EN` undefined: fixed priority, data over fetch. There is no pointer register.

## Test plan
- Reset then `if_req`=1, `if_addr`=0x10, memory[0x10]=0xA5, `MEM_LAT`=1 -> `mem_en` one cycle in G+1 with `mem_addr`=0x10, `if_ack` in G+3, `if_data`=0xA5.
- `d_req`=1, `d_we`=1, `d_addr`=0x20, `d_wdata`=0x3C -> `mem_en`=`mem_we`=1 in G+1, `d_ack` in G+2. A subsequent load of 0x20 returns `d_rdata`=0x3C.
- `if_req` and `d_req` high in the same IDLE cycle, macro undefined -> data granted first; fetch granted in the IDLE cycle after `d_ack`. With `ARB_RR_EN` and last grant=data -> fetch granted first.
- `halt`=1 with `if_req`=1 in IDLE -> no `mem_en`, `stall`=1 held. `halt` asserted during WAIT -> access completes and `if_ack` still pulses.
- `MEM_LAT`=4, read of 0x05 -> `mem_rdata` sampled 4 cycles after `mem_en`, `if_ack` 6 cycles after grant.
- `Reset` pulsed in WAIT -> all outputs 0 next cycle, no ack. A fresh request afterwards completes normally.
